// File: rtl/mlp_mac_sequencer.sv
// Operand sequencer / result collector for one dense MLP layer: fetches x and weight
// rows from synchronous memories, drives an external MAC and streams saturated outputs.
module mlp_mac_sequencer #(
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int ACC_WIDTH    = 64,
  parameter int N_INPUTS     = 8,
  parameter int N_NEURONS    = 4,
  parameter int X_ADDR_WIDTH = 3,
  parameter int W_ADDR_WIDTH = 5,
  localparam int IDX_WIDTH   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic                    busy,
  output logic                    done,
  output logic [X_ADDR_WIDTH-1:0] x_addr,
  input  logic [A_WIDTH-1:0]      x_rdata,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  input  logic [B_WIDTH-1:0]      w_rdata,
  output logic                    mac_start,
  output logic                    mac_valid,
  output logic [A_WIDTH-1:0]      mac_a,
  output logic [B_WIDTH-1:0]      mac_b,
  input  logic [ACC_WIDTH-1:0]    mac_result,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [A_WIDTH-1:0]      y_data,
  output logic [IDX_WIDTH-1:0]    y_index
);

  localparam int K_WIDTH = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [K_WIDTH-1:0]   K_LAST = K_WIDTH'(N_INPUTS - 1);
  localparam logic [IDX_WIDTH-1:0] N_LAST = IDX_WIDTH'(N_NEURONS - 1);

  // Clamp bounds expressed at accumulator width so the compare is a plain signed compare.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-A_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-A_WIDTH+1){1'b1}}, {(A_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_CAPTURE,
    S_OUT,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [K_WIDTH-1:0]     k;
  logic [IDX_WIDTH-1:0]   n;
  logic                   issue;
  logic [A_WIDTH-1:0]     sat_value;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (go) state_next = S_FETCH;
      S_FETCH:   if (k == K_LAST) state_next = S_LAST;
      S_LAST:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_OUT;
      S_OUT:     if (y_ready) state_next = (n == N_LAST) ? S_DONE : S_FETCH;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Read data trails the address by one cycle; issue marks cycles whose rdata is a real operand.
  always_comb begin
    mac_start = 1'b0;
    mac_valid = 1'b0;
    if (state == S_FETCH && issue) begin
      if (k == K_WIDTH'(1)) mac_start = 1'b1;
      else                  mac_valid = 1'b1;
    end else if (state == S_LAST && issue) begin
      if (N_INPUTS == 1) mac_start = 1'b1;
      else               mac_valid = 1'b1;
    end
  end

  always_comb begin
    if ($signed(mac_result) > SAT_MAX)      sat_value = {1'b0, {(A_WIDTH-1){1'b1}}};
    else if ($signed(mac_result) < SAT_MIN) sat_value = {1'b1, {(A_WIDTH-1){1'b0}}};
    else                                    sat_value = mac_result[A_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k       <= '0;
      n       <= '0;
      issue   <= 1'b0;
      y_data  <= '0;
      y_index <= '0;
    end else begin
      issue <= (state == S_FETCH);
      case (state)
        S_IDLE: begin
          if (go) begin
            k <= '0;
            n <= '0;
          end
        end
        S_FETCH: begin
          if (k != K_LAST) k <= k + 1'b1;
        end
        S_CAPTURE: begin
          y_data  <= sat_value;
          y_index <= n;
        end
        S_OUT: begin
          if (y_ready && n != N_LAST) begin
            n <= n + 1'b1;
            k <= '0;
          end
        end
        S_DONE: begin
          k <= '0;
          n <= '0;
        end
        default: ;
      endcase
    end
  end

  // Counters hold through LAST/CAPTURE/OUT, so addresses stay put while waiting on y_ready.
  assign x_addr  = X_ADDR_WIDTH'(k);
  assign w_addr  = W_ADDR_WIDTH'(n) * W_ADDR_WIDTH'(N_INPUTS) + W_ADDR_WIDTH'(k);
  assign mac_a   = (mac_start || mac_valid) ? x_rdata : '0;
  assign mac_b   = (mac_start || mac_valid) ? w_rdata : '0;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign y_valid = (state == S_OUT);

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Bench for mlp_mac_sequencer: memory and MAC models, table vectors, random layers
// against a dot-product reference, plus backpressure, go-while-busy and reset sequences.
module tb_mlp_mac_sequencer;

  localparam int AW = 16, BW = 16, ACCW = 64, NI = 4, NN = 2, XAW = 2, WAW = 3, IW = 1;

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, go1 = 1'b0, y_ready = 1'b1, y_ready1 = 1'b1;

  logic                   busy, done, mac_start, mac_valid, y_valid;
  logic [XAW-1:0]         x_addr;
  logic [WAW-1:0]         w_addr;
  logic signed [AW-1:0]   x_rdata, mac_a, y_data;
  logic signed [BW-1:0]   w_rdata, mac_b;
  logic signed [ACCW-1:0] mac_result;
  logic [IW-1:0]          y_index;

  logic                   busy1, done1, mac_start1, mac_valid1, y_valid1;
  logic [0:0]             x_addr1, w_addr1;
  logic signed [AW-1:0]   x_rdata1, mac_a1, y_data1;
  logic signed [BW-1:0]   w_rdata1, mac_b1;
  logic signed [ACCW-1:0] mac_result1;
  logic [0:0]             y_index1;

  int tests = 0, failed = 0;
  int starts = 0, valids = 0, viol = 0, starts1 = 0, valids1 = 0;

  always #5 clk = ~clk;

  mlp_mac_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .N_INPUTS(NI),
    .N_NEURONS(NN), .X_ADDR_WIDTH(XAW), .W_ADDR_WIDTH(WAW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .x_addr(x_addr), .x_rdata(x_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_start(mac_start), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .y_index(y_index));

  mlp_mac_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ACCW), .N_INPUTS(1),
    .N_NEURONS(1), .X_ADDR_WIDTH(1), .W_ADDR_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .busy(busy1), .done(done1),
    .x_addr(x_addr1), .x_rdata(x_rdata1), .w_addr(w_addr1), .w_rdata(w_rdata1),
    .mac_start(mac_start1), .mac_valid(mac_valid1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_result(mac_result1), .y_valid(y_valid1), .y_ready(y_ready1),
    .y_data(y_data1), .y_index(y_index1));

  // NOTE: model memories are never reset; the test loads their contents before each pass.
  logic signed [AW-1:0] xm [NI];
  logic signed [BW-1:0] wm [NI*NN];
  logic signed [AW-1:0] xm1 [2];
  logic signed [BW-1:0] wm1 [2];

  always @(posedge clk) begin
    x_rdata  <= xm[x_addr];
    w_rdata  <= wm[w_addr];
    x_rdata1 <= xm1[x_addr1];
    w_rdata1 <= wm1[w_addr1];
  end

  // MAC model: start loads a*b, valid accumulates; result is the sum scaled by >>> AW/2.
  longint acc = 0, acc1 = 0;
  always @(posedge clk) begin
    if (mac_start)      acc <= longint'(mac_a) * longint'(mac_b);
    else if (mac_valid) acc <= acc + longint'(mac_a) * longint'(mac_b);
    if (mac_start1)      acc1 <= longint'(mac_a1) * longint'(mac_b1);
    else if (mac_valid1) acc1 <= acc1 + longint'(mac_a1) * longint'(mac_b1);
  end
  assign mac_result  = acc >>> (AW/2);
  assign mac_result1 = acc1 >>> (AW/2);

  always @(negedge clk) begin
    if (mac_start)  starts++;
    if (mac_valid)  valids++;
    if (mac_start1) starts1++;
    if (mac_valid1) valids1++;
    if (mac_start && mac_valid) viol++;
    if ((mac_start || mac_valid) && y_valid) viol++;
    if (!(mac_start || mac_valid) && (mac_a != 0 || mac_b != 0)) viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [NI-1:0][AW-1:0]    x;
    logic [NI*NN-1:0][BW-1:0] w;
    logic [NN-1:0][AW-1:0]    y;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input int x0, x1, x2, x3,
                              input int w0, w1, w2, w3, w4, w5, w6, w7,
                              input int y0, y1);
    vec_t v;
    v.x[0] = AW'(x0); v.x[1] = AW'(x1); v.x[2] = AW'(x2); v.x[3] = AW'(x3);
    v.w[0] = BW'(w0); v.w[1] = BW'(w1); v.w[2] = BW'(w2); v.w[3] = BW'(w3);
    v.w[4] = BW'(w4); v.w[5] = BW'(w5); v.w[6] = BW'(w6); v.w[7] = BW'(w7);
    v.y[0] = AW'(y0); v.y[1] = AW'(y1);
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < NI; k++) xm[k] = v.x[k];
    for (int i = 0; i < NI*NN; i++) wm[i] = v.w[i];
  endtask

  // Reference: exact dot product, arithmetic shift, then signed clamp to AW bits.
  function automatic logic [AW-1:0] ref_y(input int n);
    longint s = 0;
    longint hi = (longint'(1) <<< (AW-1)) - 1;
    longint lo = -(longint'(1) <<< (AW-1));
    for (int k = 0; k < NI; k++) s += longint'(xm[k]) * longint'(wm[n*NI+k]);
    s = s >>> (AW/2);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return AW'(s);
  endfunction

  function automatic logic [AW-1:0] rnd_val(input bit wide);
    int v;
    if (wide) return AW'($urandom);
    v = int'($urandom_range(0, 2047)) - 1024;
    return AW'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one full layer pass; go is held for hold_go cycles after acceptance to prove it is ignored.
  task automatic run_layer(input string tag, input logic [NN-1:0][AW-1:0] ey,
                           input bit timed, input bit rand_ready, input int hold_go);
    int c;
    starts = 0; valids = 0; viol = 0;
    go = 1'b1;
    tick();
    c = 0;
    for (int n = 0; n < NN; n++) begin
      while (c < 200) begin
        go = (c < hold_go);
        if (rand_ready) y_ready = 1'($urandom_range(0, 1));
        if (y_valid && y_ready) break;
        tick();
        c++;
      end
      check($sformatf("%s y_valid n%0d", tag, n), y_valid, 1);
      check($sformatf("%s y_data n%0d", tag, n), y_data, $signed(ey[n]));
      check($sformatf("%s y_index n%0d", tag, n), y_index, n);
      if (timed) check($sformatf("%s y_valid cycle n%0d", tag, n), c, NI + 2 + n*(NI + 3));
      tick();
      c++;
    end
    go = 1'b0;
    y_ready = 1'b1;
    check({tag, " done pulse"}, done, 1);
    check({tag, " busy in DONE"}, busy, 1);
    tick();
    check({tag, " done after"}, done, 0);
    check({tag, " busy after"}, busy, 0);
    check({tag, " mac_start count"}, starts, NN);
    check({tag, " mac_valid count"}, valids, NN*(NI - 1));
    check({tag, " mac protocol"}, viol, 0);
  endtask

  initial begin
    int c;
    logic [XAW-1:0] xa;
    logic [WAW-1:0] wa;

    vecs[0] = mk(256, 512, -256, 128, 256, 256, 256, 256, 128, 128, 128, 128, 640, 320);
    vecs[1] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 32767, 0);
    vecs[2] = mk(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,
                 -32768, -32768, -32768, -32768, -32768, -32768);
    vecs[3] = mk(32767, -32768, 0, 0, 256, 0, 0, 0, 0, 256, 0, 0, 32767, -32768);
    vecs[4] = mk(32767, 256, 0, 0, 256, 1, 0, 0, -256, -2, 0, 0, 32767, -32768);
    vecs[5] = mk(-1, 3, 0, 0, 1, 0, 0, 0, 0, 100, 0, 0, -1, 1);
    xm1[0] = 512; xm1[1] = 7;
    wm1[0] = 384; wm1[1] = 9;

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mac_start", mac_start, 0);
    check("reset mac_valid", mac_valid, 0);
    check("reset y_valid", y_valid, 0);
    check("reset y_data", y_data, 0);
    check("reset y_index", y_index, 0);
    check("reset x_addr", x_addr, 0);
    check("reset w_addr", w_addr, 0);
    check("reset busy1", busy1, 0);
    rst_n = 1'b1;
    tick();

    // Single-input configuration: one mac_start per neuron, never mac_valid.
    starts1 = 0; valids1 = 0;
    go1 = 1'b1;
    tick();
    go1 = 1'b0;
    c = 0;
    while (!y_valid1 && c < 20) begin
      tick();
      c++;
    end
    check("n1 y_valid cycle", c, 3);
    check("n1 y_data", y_data1, 768);
    check("n1 y_index", y_index1, 0);
    tick();
    check("n1 done", done1, 1);
    check("n1 mac_start count", starts1, 1);
    check("n1 mac_valid count", valids1, 0);
    tick();
    check("n1 busy after", busy1, 0);

    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      run_layer($sformatf("vec%0d", i), vecs[i].y, 1'b1, 1'b0, 0);
    end

    load_vec(vecs[0]);
    run_layer("go held while busy", vecs[0].y, 1'b1, 1'b0, 9);

    // Backpressure on neuron 0, with a stray go pulse during the stall.
    y_ready = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    c = 0;
    while (!y_valid && c < 50) begin
      tick();
      c++;
    end
    check("bp first valid cycle", c, NI + 2);
    xa = x_addr;
    wa = w_addr;
    for (int i = 0; i < 5; i++) begin
      go = (i == 2);
      tick();
      check($sformatf("bp y_valid %0d", i), y_valid, 1);
      check($sformatf("bp y_data %0d", i), y_data, 640);
      check($sformatf("bp y_index %0d", i), y_index, 0);
      check($sformatf("bp mac_start %0d", i), mac_start, 0);
      check($sformatf("bp mac_valid %0d", i), mac_valid, 0);
      check($sformatf("bp x_addr %0d", i), x_addr, xa);
      check($sformatf("bp w_addr %0d", i), w_addr, wa);
    end
    go = 1'b0;
    y_ready = 1'b1;
    tick();
    check("bp y_valid dropped", y_valid, 0);
    check("bp next x_addr", x_addr, 0);
    check("bp next w_addr", w_addr, NI);
    check("bp busy", busy, 1);
    c = 0;
    while (!y_valid && c < 50) begin
      tick();
      c++;
    end
    check("bp n1 valid cycle", c, NI + 2);
    check("bp n1 y_data", y_data, 320);
    check("bp n1 y_index", y_index, 1);
    tick();
    check("bp done", done, 1);
    tick();
    check("bp busy after", busy, 0);

    // Reset during FETCH cycle 2, then a clean rerun of the first layer.
    load_vec(vecs[0]);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("rst cycle0 mac_start", mac_start, 0);
    check("rst cycle0 mac_valid", mac_valid, 0);
    tick();
    check("rst cycle1 mac_start", mac_start, 1);
    check("rst cycle1 mac_a", mac_a, 256);
    check("rst cycle1 mac_b", mac_b, 256);
    check("rst cycle1 x_addr", x_addr, 1);
    tick();
    check("rst cycle2 mac_valid", mac_valid, 1);
    check("rst cycle2 mac_start", mac_start, 0);
    check("rst cycle2 mac_a", mac_a, 512);
    check("rst cycle2 w_addr", w_addr, 2);
    rst_n = 1'b0;
    tick();
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst mac_start", mac_start, 0);
    check("midrst mac_valid", mac_valid, 0);
    check("midrst mac_a", mac_a, 0);
    check("midrst y_valid", y_valid, 0);
    check("midrst y_data", y_data, 0);
    check("midrst y_index", y_index, 0);
    check("midrst x_addr", x_addr, 0);
    check("midrst w_addr", w_addr, 0);
    rst_n = 1'b1;
    tick();
    check("midrst idle after release", busy, 0);
    run_layer("after reset", vecs[0].y, 1'b1, 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      logic [NN-1:0][AW-1:0] ey;
      for (int k = 0; k < NI; k++) xm[k] = rnd_val(r % 3 == 0);
      for (int i = 0; i < NI*NN; i++) wm[i] = rnd_val(r % 3 == 0);
      for (int n = 0; n < NN; n++) ey[n] = ref_y(n);
      run_layer($sformatf("rand%0d", r), ey, 1'b0, 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mlp_mac_sequencer.md
Name: mlp_mac_sequencer

Overview:
- Operand sequencer and result collector that drives the MAC unit (MLP_mac) for one dense layer.
- Fetches the input vector x and each neuron's weight row from two synchronous-read memories.
- Drives the MAC with start/valid and operands a/b.
- Captures the MAC result, saturates it to the data width, and streams one output per neuron over a valid/ready handshake.

Parameters:
A_WIDTH, 16, signed width of x samples; also the width of mac_a and y_data
B_WIDTH, 16, signed width of weights and mac_b
ACC_WIDTH, 64, width of mac_result
N_INPUTS, 8, dot-product length per neuron; must be >= 1
N_NEURONS, 4, neurons per layer; must be >= 1
X_ADDR_WIDTH, 3, must satisfy 2^X_ADDR_WIDTH >= N_INPUTS
W_ADDR_WIDTH, 5, must satisfy 2^W_ADDR_WIDTH >= N_INPUTS*N_NEURONS

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
go  in  1  start a layer pass; sampled only in IDLE
busy  out  1  high from the edge after go is accepted until DONE exits
done  out  1  one-cycle pulse after the last output handshake
x_addr  out  X_ADDR_WIDTH  x memory address; 1-cycle read latency
x_rdata  in  A_WIDTH  signed x memory read data
w_addr  out  W_ADDR_WIDTH  weight address = n*N_INPUTS + k
w_rdata  in  B_WIDTH  signed weight read data
mac_start  out  1  to MAC start: load a*b
mac_valid  out  1  to MAC valid: accumulate a*b
mac_a  out  A_WIDTH  x_rdata when mac_start|mac_valid, else 0
mac_b  out  B_WIDTH  w_rdata when mac_start|mac_valid, else 0
mac_result  in  ACC_WIDTH  MAC output, already scaled by >>> A_WIDTH/2
y_valid  out  1  output valid
y_ready  in  1  downstream ready
y_data  out  A_WIDTH  saturated neuron output
y_index  out  clog2(N_NEURONS) (min 1)  neuron number n of y_data

Behaviour:
- Reset (rst_n=0 at an edge), regardless of state: state=IDLE; counters n=k=0.
  - busy, done, mac_start, mac_valid, y_valid = 0.
  - y_data=0, y_index=0, x_addr=0, w_addr=0.
- States: IDLE, FETCH, LAST, CAPTURE, OUT, DONE.
- IDLE: go=1 -> FETCH with n=0, k=0. go in any other state is ignored.
- FETCH: lasts N_INPUTS cycles, k=0..N_INPUTS-1.
  - x_addr=k and w_addr=n*N_INPUTS+k, both combinational from registered counters.
  - A registered one-cycle issue flag marks the returned data.
  - In FETCH cycle k>=1, data for index k-1 is on rdata: mac_start=1 if k-1==0, else mac_valid=1.
  - After k=N_INPUTS-1 -> LAST.
- LAST: data for index N_INPUTS-1 is present.
  - mac_valid=1, or mac_start=1 if N_INPUTS==1.
  - mac_start and mac_valid are never high together.
  - -> CAPTURE.
- CAPTURE: mac_result now holds the full sum.
  - Register y_data = sat(mac_result) and y_index=n.
  - -> OUT; y_valid=1 from the next cycle.
- Saturation: signed clamp of mac_result to [-2^(A_WIDTH-1), 2^(A_WIDTH-1)-1]; otherwise take the low A_WIDTH bits.
- OUT: y_valid=1; y_data and y_index held stable until y_valid & y_ready at an edge. At that edge:
  - if n<N_NEURONS-1: n++, k=0, -> FETCH;
  - else -> DONE.
  - y_valid drops in the cycle after the handshake.
  - No MAC activity while in OUT.
- DONE: done=1 for exactly one cycle; busy=0 from the next cycle; -> IDLE.
- Latency: with the first FETCH cycle = cycle 0, y_valid is first high in cycle N_INPUTS+2. With y_ready held high, throughput is one neuron per N_INPUTS+3 cycles.
- Reset mid-operation aborts cleanly. The partial MAC accumulator is irrelevant because the next neuron always begins with mac_start.

Test Plan:
- N_INPUTS=4, N_NEURONS=2, team MAC instantiated. Q8.8 data: x=[256,512,-256,128]; w row0=[256,256,256,256]; row1=[128,128,128,128]; y_ready=1; pulse go.
  - Required: y_data=640 (y_index=0) in cycle 6, then y_data=320 (y_index=1) in cycle 13.
  - done pulses once; busy low afterwards.
- Positive saturation: x all 0x7FFF, w row0 all 0x7FFF -> raw 16776192 -> y_data=32767.
- Negative saturation: w all 0x8000 -> y_data=-32768 (0x8000).
- Backpressure: y_ready=0 for 5 cycles in OUT -> y_valid held, y_data/y_index stable, mac_start=mac_valid=0, addresses unchanged. Then y_ready=1 -> one handshake, next neuron fetch begins.
- Control/reset:
  - go re-pulsed while busy -> ignored, results unchanged.
  - rst_n=0 during FETCH cycle 2 -> next cycle all outputs 0, state IDLE.
  - After release, a new go reproduces the first scenario's values exactly.
- Edge config N_INPUTS=1: x=[512], w=[384] -> mac_start only (never mac_valid), y_data=768 in cycle 3.
